// File: rtl/timer_pkg.sv
// Shared register map and control-bit layout for the multi-channel interval timer.
// Imported by the channel sub-module and the top-level bus slave.
package timer_pkg;

  // Channel slot register offsets
  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_CONTROL  = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SNAP     = 2'd3;

  // Global slot register offsets
  localparam logic [1:0] REG_PRESCALE = 2'd0;
  localparam logic [1:0] REG_PENDING  = 2'd1;
  localparam logic [1:0] REG_GSTART   = 2'd2;
  localparam logic [1:0] REG_GSTOP    = 2'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO    = 0;
  localparam int STAT_RUN   = 1;

  // Stored part of CONTROL; field order matches writedata[1:0]
  typedef struct packed {
    logic cont;
    logic ito;
  } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: counter, period, sticky timeout, run state,
// stored control bits, snapshot capture and the post-PERIOD-write forced reload.
module timer_channel
  import timer_pkg::*;
#(
  parameter int          COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_tick,
  input  logic               i_wr_status,
  input  logic               i_wr_control,
  input  logic               i_wr_period,
  input  logic               i_wr_snap,
  input  logic [31:0]        i_wdata,
  input  logic               i_gstart,
  input  logic               i_gstop,
  output logic [COUNT_W-1:0] o_period,
  output logic [COUNT_W-1:0] o_snap,
  output logic               o_to,
  output logic               o_run,
  output ctrl_t              o_ctrl
);

  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_period;
  logic [COUNT_W-1:0] r_snap;
  logic               r_to;
  logic               r_run;
  logic               r_force;
  ctrl_t              r_ctrl;

  logic w_expire;
  logic w_start;
  logic w_stop;
  logic w_run_next;

  // A pending forced reload takes priority over counting, so no expiry that cycle
  assign w_expire = i_tick && r_run && !r_force && (r_count == '0);
  assign w_start  = (i_wr_control && i_wdata[CTRL_START]) || i_gstart;
  assign w_stop   = (i_wr_control && i_wdata[CTRL_STOP]) || i_gstop || i_wr_period;

  // Later assignments win: expiry stop, then explicit stop, then start
  always_comb begin
    w_run_next = r_run;
    if (w_expire && !r_ctrl.cont) w_run_next = 1'b0;
    if (w_stop)                   w_run_next = 1'b0;
    if (w_start)                  w_run_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= COUNT_W'(RESET_PERIOD);
      r_period <= COUNT_W'(RESET_PERIOD);
      r_snap   <= '0;
      r_to     <= 1'b0;
      r_run    <= 1'b0;
      r_force  <= 1'b0;
      r_ctrl   <= '0;
    end else begin
      r_run   <= w_run_next;
      r_force <= i_wr_period;
      if (i_wr_period)  r_period <= i_wdata[COUNT_W-1:0];
      if (i_wr_control) r_ctrl   <= ctrl_t'(i_wdata[1:0]);
      if (r_force)
        r_count <= r_period;
      else if (i_tick && r_run)
        r_count <= (r_count == '0) ? r_period : r_count - COUNT_W'(1);
      if (w_expire)
        r_to <= 1'b1;
      else if (i_wr_status)
        r_to <= 1'b0;
      if (i_wr_snap) r_snap <= r_count;
    end
  end

  assign o_period = r_period;
  assign o_snap   = r_snap;
  assign o_to     = r_to;
  assign o_run    = r_run;
  assign o_ctrl   = r_ctrl;

endmodule

// File: rtl/multi_channel_interval_timer.sv
// Avalon-MM slave wrapping NUM_CH timer channels with a shared prescaler,
// global start/stop/pending registers, 1-cycle registered read data and a level IRQ.
module multi_channel_interval_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int COUNT_W      = 32,
  parameter int PRESCALE_W   = 16,
  parameter int RESET_PERIOD = 9,
  parameter int ADDR_W       = $clog2(NUM_CH + 1) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int SLOT_W = ADDR_W - 2;

  logic [SLOT_W-1:0]     w_slot;
  logic [1:0]            w_reg;
  logic                  w_wr;
  logic                  w_wr_glb;
  logic                  w_wr_ps;
  logic                  w_tick;
  logic [PRESCALE_W-1:0] r_ps;
  logic [PRESCALE_W-1:0] r_ps_cnt;
  logic [31:0]           w_rdata;

  logic [NUM_CH-1:0]  w_to;
  logic [NUM_CH-1:0]  w_run;
  logic [NUM_CH-1:0]  w_ito;
  logic [NUM_CH-1:0]  w_cont;
  logic [NUM_CH-1:0]  w_pending;
  ctrl_t              w_ctrl   [NUM_CH];
  logic [COUNT_W-1:0] w_period [NUM_CH];
  logic [COUNT_W-1:0] w_snap   [NUM_CH];

  assign w_slot   = address[ADDR_W-1:2];
  assign w_reg    = address[1:0];
  assign w_wr     = chipselect && !write_n;
  assign w_wr_glb = w_wr && (w_slot == SLOT_W'(NUM_CH));
  assign w_wr_ps  = w_wr_glb && (w_reg == REG_PRESCALE);
  assign w_tick   = (r_ps_cnt == r_ps);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_wr_ch;
      assign w_wr_ch = w_wr && (w_slot == SLOT_W'(gi));

      timer_channel #(
        .COUNT_W      (COUNT_W),
        .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (w_tick),
        .i_wr_status  (w_wr_ch && (w_reg == REG_STATUS)),
        .i_wr_control (w_wr_ch && (w_reg == REG_CONTROL)),
        .i_wr_period  (w_wr_ch && (w_reg == REG_PERIOD)),
        .i_wr_snap    (w_wr_ch && (w_reg == REG_SNAP)),
        .i_wdata      (writedata),
        .i_gstart     (w_wr_glb && (w_reg == REG_GSTART) && writedata[gi]),
        .i_gstop      (w_wr_glb && (w_reg == REG_GSTOP) && writedata[gi]),
        .o_period     (w_period[gi]),
        .o_snap       (w_snap[gi]),
        .o_to         (w_to[gi]),
        .o_run        (w_run[gi]),
        .o_ctrl       (w_ctrl[gi])
      );

      assign w_ito[gi]     = w_ctrl[gi].ito;
      assign w_cont[gi]    = w_ctrl[gi].cont;
      assign w_pending[gi] = w_to[gi] && w_ito[gi];
    end
  endgenerate

  assign irq = |w_pending;

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_slot == SLOT_W'(c)) begin
        case (w_reg)
          REG_STATUS: begin
            w_rdata[STAT_TO]  = w_to[c];
            w_rdata[STAT_RUN] = w_run[c];
          end
          REG_CONTROL: begin
            w_rdata[CTRL_ITO]  = w_ito[c];
            w_rdata[CTRL_CONT] = w_cont[c];
          end
          REG_PERIOD: w_rdata[COUNT_W-1:0] = w_period[c];
          REG_SNAP:   w_rdata[COUNT_W-1:0] = w_snap[c];
          default:    w_rdata = '0;
        endcase
      end
    end
    if (w_slot == SLOT_W'(NUM_CH)) begin
      case (w_reg)
        REG_PRESCALE: w_rdata[PRESCALE_W-1:0] = r_ps;
        REG_PENDING:  w_rdata[NUM_CH-1:0]     = w_pending;
        default:      w_rdata = '0;
      endcase
    end
  end

  // Prescaler restarts from 0 whenever PS is rewritten so the new rate starts cleanly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps     <= '0;
      r_ps_cnt <= '0;
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
      if (w_wr_ps) begin
        r_ps     <= writedata[PRESCALE_W-1:0];
        r_ps_cnt <= '0;
      end else if (w_tick) begin
        r_ps_cnt <= '0;
      end else begin
        r_ps_cnt <= r_ps_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed bench for multi_channel_interval_timer: reads are scoreboarded via a queue
// of expected words popped when readdata becomes valid one cycle later.
module tb_multi_channel_interval_timer;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = $clog2(NUM_CH + 1) + 2;

  localparam logic [ADDR_W-1:0] CH0_STAT = 5'd0,  CH0_CTRL = 5'd1,  CH0_PER = 5'd2,  CH0_SNAP = 5'd3;
  localparam logic [ADDR_W-1:0] CH1_STAT = 5'd4,  CH1_CTRL = 5'd5,  CH1_PER = 5'd6;
  localparam logic [ADDR_W-1:0] CH2_STAT = 5'd8,  CH2_CTRL = 5'd9,  CH2_PER = 5'd10, CH2_SNAP = 5'd11;
  localparam logic [ADDR_W-1:0] CH3_STAT = 5'd12, CH3_CTRL = 5'd13, CH3_PER = 5'd14;
  localparam logic [ADDR_W-1:0] G_PS = 5'd16, G_PEND = 5'd17, G_START = 5'd18, G_STOP = 5'd19;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  int vectors = 0;
  int fails   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  multi_channel_interval_timer #(
    .NUM_CH       (NUM_CH),
    .COUNT_W      (32),
    .PRESCALE_W   (16),
    .RESET_PERIOD (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled on the following posedge; returns at next negedge
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    $display("wr addr=0x%02h data=0x%08h", a, d);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Read issued at a negedge, expected word queued; popped and compared one cycle later
  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    chipselect = 1'b0;
    $display("rd addr=0x%02h data=0x%08h", a, readdata);
    check(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;

    // Reset state
    rd(CH0_PER,  32'd9, "rst_ch0_period");
    rd(CH0_STAT, 32'd0, "rst_ch0_status");
    rd(G_PS,     32'd0, "rst_prescale");
    rd(CH0_CTRL, 32'd0, "rst_ch0_control");
    check("rst_irq_idle", {31'd0, irq}, 32'h0);

    // ch1 continuous, PERIOD=4, PS=0: timeout every 5 clocks
    wr(CH1_PER, 32'd4);
    wr(CH1_CTRL, 32'h7);
    repeat (4) @(negedge clk);
    check("ch1_irq_before_to", {31'd0, irq}, 32'h0);
    @(negedge clk);
    check("ch1_irq_first_to", {31'd0, irq}, 32'h1);
    wr(CH1_STAT, 32'h0);
    check("ch1_irq_cleared", {31'd0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    check("ch1_irq_before_2nd", {31'd0, irq}, 32'h0);
    @(negedge clk);
    check("ch1_irq_second_to", {31'd0, irq}, 32'h1);
    wr(CH1_CTRL, 32'h8);
    wr(CH1_STAT, 32'h0);
    rd(CH1_STAT, 32'd0, "ch1_stopped");

    // ch2 one-shot with PS=3, PERIOD=2
    wr(G_PS, 32'd3);
    wr(CH2_PER, 32'd2);
    wr(CH2_CTRL, 32'h4);
    repeat (9) @(negedge clk);
    rd(CH2_STAT, 32'h2, "ch2_run_before_to");
    rd(CH2_STAT, 32'h1, "ch2_to_oneshot");
    repeat (20) @(negedge clk);
    wr(CH2_SNAP, 32'h0);
    rd(CH2_SNAP, 32'd2, "ch2_holds_period");
    rd(CH2_STAT, 32'h1, "ch2_single_to");
    rd(CH2_CTRL, 32'h0, "ch2_ctrl_pulses_read0");
    wr(G_PS, 32'd0);
    wr(CH2_STAT, 32'h0);

    // Global start of ch0/ch2, then global stop of ch0
    wr(CH3_PER, 32'd6);
    wr(CH0_CTRL, 32'h2);
    wr(CH2_CTRL, 32'h2);
    wr(G_START, 32'h5);
    rd(CH0_STAT, 32'h2, "gstart_ch0_run");
    rd(CH2_STAT, 32'h2, "gstart_ch2_run");
    rd(CH1_STAT, 32'h0, "gstart_ch1_idle");
    rd(CH3_STAT, 32'h0, "gstart_ch3_idle");
    wr(G_STOP, 32'h1);
    wr(CH0_SNAP, 32'h0);
    rd(CH0_SNAP, 32'd4, "gstop_ch0_snap");
    repeat (7) @(negedge clk);
    wr(CH0_SNAP, 32'h0);
    rd(CH0_SNAP, 32'd4, "gstop_ch0_frozen");
    rd(CH0_STAT, 32'h0, "gstop_ch0_status");
    wr(G_STOP, 32'h4);
    wr(CH2_STAT, 32'h0);

    // ch3: timeout event coincides with a STATUS write; set must win
    wr(CH3_PER, 32'd3);
    wr(CH3_CTRL, 32'h7);
    repeat (3) @(negedge clk);
    wr(CH3_STAT, 32'h0);
    check("ch3_irq_after_race", {31'd0, irq}, 32'h1);
    rd(CH3_STAT, 32'h3, "ch3_to_set_wins");
    rd(G_PEND, 32'h8, "pending_ch3");

    // Asynchronous reset mid-count with irq high
    rd(CH3_STAT, 32'h3, "ch3_before_reset");
    check("irq_before_reset", {31'd0, irq}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    check("async_rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(CH3_STAT, 32'h0, "post_rst_ch3_status");
    rd(CH3_PER,  32'd9, "post_rst_ch3_period");
    rd(G_PEND,   32'h0, "post_rst_pending");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/multi_channel_interval_timer.md
# multi_channel_interval_timer

Parametrised successor to the single-channel Avalon-MM interval timer in the Nios II SoC. It provides NUM_CH independent down-counting channels of COUNT_W bits each, sharing one programmable prescaler, on a 32-bit Avalon-MM slave with fixed 1-cycle read latency. Per-channel timeout flags combine into one level-sensitive IRQ to the CPU, and a global pending register lets the ISR find the source channel in one read.

## Interface
- NUM_CH, 4: number of timer channels, 1..8.
- COUNT_W, 32: counter/period width, 8..32.
- PRESCALE_W, 16: prescaler width, 1..32.
- RESET_PERIOD, 9: reset value of every period register and counter.
- ADDR_W, $clog2(NUM_CH+1)+2: word-address width (derived, not overridden).
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address; bits [ADDR_W-1:2] = slot, bits [1:0] = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  OR over channels of (TO && ITO).

## Operation
- Channel slot c (0..NUM_CH-1), registers:
  - 0 STATUS: bit0 TO (sticky timeout), bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Only [1:0] are stored; START and STOP are write-only pulses that read back 0.
  - 2 PERIOD: [COUNT_W-1:0]. A write stops the channel and forces a reload on the next cycle.
  - 3 SNAPSHOT: a write captures the live counter; a read returns the captured value.
- Global slot NUM_CH:
  - 0 PRESCALE: [PRESCALE_W-1:0], value PS.
  - 1 PENDING: bit c = TO_c && ITO_c (read-only).
  - 2 GSTART: a write starts every channel whose writedata bit is 1.
  - 3 GSTOP: a write stops every channel whose writedata bit is 1.
- Prescaler:
  - Free-running counter. It emits a tick and wraps to 0 when it equals PS, so a tick occurs every PS+1 clocks; PS=0 ticks every clock.
  - A PRESCALE write resets the prescaler counter to 0.
- Per channel, on tick && RUN:
  - counter==0: reload PERIOD, pulse timeout, clear RUN if CONT=0.
  - otherwise: decrement.
- Timeout cadence: PERIOD=P gives P+1 ticks between timeouts.
- Force reload: the cycle after a PERIOD write, counter loads the new period regardless of tick.
- Precedence:
  - START beats STOP: CONTROL with both bits set, or GSTART/GSTOP in different cycles, resolve by last write.
  - A START in the same cycle as a PERIOD-induced stop: START wins.
  - A timeout event in the same cycle as a STATUS write: set wins, so the event is never lost.
- Unused bits and unmapped slots read 0. Writes to them are ignored.

## Timing
- Reset values:
  - readdata=0, irq=0, TO=0, RUN=0, CONTROL=0, PS=0.
  - PERIOD and counter = RESET_PERIOD; snapshot=0; prescaler=0.
- readdata is registered from the address mux every cycle. Read latency is 1 (readLatency=1, no waitrequest).
- Writes take effect at the clock edge on which chipselect && !write_n is sampled. RUN reads 1 on the read issued the cycle after a START write.
- TO rises on the edge that reloads from 0. irq rises combinationally from the TO register, so it is high that same cycle.
- Reset asserted mid-count returns all state to reset values immediately (asynchronously). The first tick after release occurs PS+1 = 1 clock later.

## Structure
- Shared package timer_pkg:
  - register-offset constants: REG_STATUS, REG_CONTROL, REG_PERIOD, REG_SNAP, REG_PRESCALE, REG_PENDING, REG_GSTART, REG_GSTOP.
  - control-bit index constants.
- One sub-module, timer_channel: counter, RUN, TO, CONTROL, PERIOD, snapshot and force_reload for one channel. The top instantiates it NUM_CH times in a generate loop.
- Top level: prescaler, address decode, read mux, readdata register, irq OR.

## Test plan
- After reset, read ch0 PERIOD then STATUS: 9, then 0; irq=0.
- ch1: PERIOD=4, PS=0, CONTROL=0x7 (ITO|CONT|START). TO sets and irq=1 every 5 clocks. Writing STATUS clears TO; irq drops the next cycle.
- ch2: PS=3, PERIOD=2, CONTROL=0x4 (one-shot). Exactly one timeout after 12 clocks, then RUN=0 and the counter holds 2.
- Write GSTART=0b0101 with all periods different: only ch0 and ch2 run. Then GSTOP=0b0001: ch0 freezes and its snapshot write/read returns the frozen count.
- Force a timeout event in the same cycle as a STATUS write on ch3: TO reads 1 afterwards. PENDING equals 1<<3 when ITO=1.
- Assert reset mid-count with irq high: irq, readdata and RUN go to 0 without a clock edge.
